// File: rtl/dac_tx_sequencer.sv
// dac_tx_sequencer: I/Q burst sequencer between the sample source and the DAC.
// Optional macro DAC_SEQ_UFLOW_CNT_EN adds a saturating underflow counter.
module dac_tx_sequencer #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    input  logic             start_i,
    input  logic             continuous_i,
    input  logic [7:0]       rate_i,
    input  logic [LEN_W-1:0] burst_len_i,
    input  logic [LEN_W-1:0] guard_len_i,
    input  logic             src_valid_i,
    input  logic [13:0]      src_i_i,
    input  logic [13:0]      src_q_i,
    output logic             src_ready_o,
    output logic             strobe_o,
    output logic [13:0]      tx_i_o,
    output logic [13:0]      tx_q_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             uflow_o,
    output logic [15:0]      uflow_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX    = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [7:0]       rate_q;
    logic [LEN_W-1:0] burst_q;
    logic [LEN_W-1:0] guard_q;

    logic [7:0]       div_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] len_cur;

    logic             tick;
    logic             period_end;
    logic             launch;

    logic             strobe_d;
    logic             uflow_d;
    logic             done_d;
    logic [13:0]      tx_i_d;
    logic [13:0]      tx_q_d;

    // Tick and end-of-state detection. A state ends at the last cycle of
    // the period holding its final tick, so the next state's first tick
    // keeps the rate_q+1 spacing.
    always_comb begin
        tick       = (state_q != IDLE) && (div_q == 8'd0);
        len_cur    = (state_q == GUARD) ? guard_q : burst_q;
        cnt_nxt    = cnt_q + {{(LEN_W-1){1'b0}}, tick};
        period_end = (state_q != IDLE)
                   && (div_q == rate_q)
                   && (cnt_nxt == len_cur);
        launch     = (state_q == IDLE) && (state_d == TX);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ena_i low overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && (burst_len_i != '0)) begin
                    state_d = TX;
                end
            end
            TX: begin
                if (period_end) begin
                    if (guard_q != '0) begin
                        state_d = GUARD;
                    end else if (!continuous_i) begin
                        state_d = IDLE;
                    end
                end
            end
            GUARD: begin
                if (period_end) begin
                    state_d = continuous_i ? TX : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ena_i) begin
            state_d = IDLE;
        end
    end

    // Burst parameters are captured at launch and frozen for the burst
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rate_q  <= '0;
            burst_q <= '0;
            guard_q <= '0;
        end else if (launch) begin
            rate_q  <= rate_i;
            burst_q <= burst_len_i;
            guard_q <= guard_len_i;
        end
    end

    // Rate divider and tick counter, cleared on every state entry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if ((state_q == IDLE) || (state_d == IDLE)
                     || period_end) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= (div_q == rate_q) ? 8'd0 : div_q + 8'd1;
            cnt_q <= cnt_nxt;
        end
    end

    // Output decode: next values of the registered outputs and the
    // combinational source handshake
    always_comb begin
        src_ready_o = 1'b0;
        strobe_d    = 1'b0;
        uflow_d     = 1'b0;
        tx_i_d      = (state_d == IDLE) ? 14'd0 : tx_i_o;
        tx_q_d      = (state_d == IDLE) ? 14'd0 : tx_q_o;
        done_d      = ena_i && period_end && (state_d == IDLE);
        if (ena_i && tick) begin
            unique case (state_q)
                TX: begin
                    src_ready_o = 1'b1;
                    strobe_d    = 1'b1;
                    if (src_valid_i) begin
                        tx_i_d = src_i_i;
                        tx_q_d = src_q_i;
                    end else begin
                        tx_i_d  = 14'd0;
                        tx_q_d  = 14'd0;
                        uflow_d = 1'b1;
                    end
                end
                GUARD: begin
                    strobe_d = 1'b1;
                    tx_i_d   = 14'd0;
                    tx_q_d   = 14'd0;
                end
                default: ;
            endcase
        end
    end

    // Registered DAC-side outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            strobe_o <= 1'b0;
            uflow_o  <= 1'b0;
            done_o   <= 1'b0;
            tx_i_o   <= '0;
            tx_q_o   <= '0;
        end else begin
            strobe_o <= strobe_d;
            uflow_o  <= uflow_d;
            done_o   <= done_d;
            tx_i_o   <= tx_i_d;
            tx_q_o   <= tx_q_d;
        end
    end

    assign busy_o = (state_q != IDLE);

`ifdef DAC_SEQ_UFLOW_CNT_EN
    logic [15:0] ucnt_q;

    // Saturating underflow count, in step with the uflow_o pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ucnt_q <= '0;
        end else if (uflow_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign uflow_cnt_o = ucnt_q;
`else
    assign uflow_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// tb_dac_tx_sequencer: randomized bursts against an event-list model.
// Honours DAC_SEQ_UFLOW_CNT_EN for the counter expectations.
module tb_dac_tx_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ena_i;
    logic        start_i;
    logic        continuous_i;
    logic [7:0]  rate_i;
    logic [15:0] burst_len_i;
    logic [15:0] guard_len_i;
    logic        src_valid_i;
    logic [13:0] src_i_i;
    logic [13:0] src_q_i;
    logic        src_ready_o;
    logic        strobe_o;
    logic [13:0] tx_i_o;
    logic [13:0] tx_q_o;
    logic        busy_o;
    logic        done_o;
    logic        uflow_o;
    logic [15:0] uflow_cnt_o;

    dac_tx_sequencer #(.LEN_W(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .ena_i        (ena_i),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .rate_i       (rate_i),
        .burst_len_i  (burst_len_i),
        .guard_len_i  (guard_len_i),
        .src_valid_i  (src_valid_i),
        .src_i_i      (src_i_i),
        .src_q_i      (src_q_i),
        .src_ready_o  (src_ready_o),
        .strobe_o     (strobe_o),
        .tx_i_o       (tx_i_o),
        .tx_q_o       (tx_q_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .uflow_o      (uflow_o),
        .uflow_cnt_o  (uflow_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          c;
        logic [13:0] i;
        logic [13:0] q;
        logic        u;
    } ev_t;

    ev_t obs[$];
    ev_t expq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  sidx = 0;
    bit  rec = 0;
    int  n_done;
    int  done_cyc;
    int  busy_fall;
    int  s_cyc;
    int  exp_uf = 0;

    function automatic logic [13:0] smp_i(input int k);
        return 14'((k * 37 + 1) & 16383);
    endfunction

    function automatic logic [13:0] smp_q(input int k);
        return 14'((k * 101 + 8191) & 16383);
    endfunction

    function automatic logic [31:0] exp_ucnt();
`ifdef DAC_SEQ_UFLOW_CNT_EN
        return (exp_uf > 65535) ? 32'hFFFF : 32'(exp_uf);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // One clock: handshake seen before the edge advances the source,
    // outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic hs;
        ev_t  e;
        @(negedge clk_i);
        hs = src_ready_o & src_valid_i;
        @(posedge clk_i);
        #1;
        cyc++;
        if (hs) sidx++;
        src_i_i = smp_i(sidx);
        src_q_i = smp_q(sidx);
        if (rec) begin
            if (strobe_o) begin
                e.c = cyc;
                e.i = tx_i_o;
                e.q = tx_q_o;
                e.u = uflow_o;
                obs.push_back(e);
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!busy_o && busy_fall < 0 && cyc >= s_cyc)
                busy_fall = cyc;
        end
    endtask

    // drop: cycles after burst start during which continuous_i is high
    // (0 = one-shot). miss: tick index forced invalid (-1 = none).
    task automatic run_burst(input string tag, input int r, input int b,
                             input int g, input int drop, input int vpct,
                             input int miss);
        int  c0, s, p, l, nb, e, k;
        bit  vld[];
        ev_t ev;
        c0 = cyc;
        s  = c0 + 1;
        p  = r + 1;
        l  = b + g;
        nb = (drop <= 0) ? 1 : (drop + l * p) / (l * p);
        e  = s + nb * l * p;
        vld = new[e - c0 + 3];
        foreach (vld[i]) vld[i] = ($urandom_range(99) < vpct);
        if (miss >= 0) vld[1 + miss * p] = 1'b0;
        k = sidx;
        expq.delete();
        obs.delete();
        for (int m = 0; m < nb; m++) begin
            for (int j = 0; j < l; j++) begin
                int t;
                t = s + (m * l + j) * p;
                ev.c = t + 1;
                ev.i = '0;
                ev.q = '0;
                ev.u = 1'b0;
                if (j < b) begin
                    if (vld[t - c0]) begin
                        ev.i = smp_i(k);
                        ev.q = smp_q(k);
                        k++;
                    end else begin
                        ev.u = 1'b1;
                        exp_uf++;
                    end
                end
                expq.push_back(ev);
            end
        end
        n_done = 0;
        done_cyc = -1;
        busy_fall = -1;
        s_cyc = s;
        rec = 1;
        rate_i = 8'(r);
        burst_len_i = 16'(b);
        guard_len_i = 16'(g);
        start_i = 1'b1;
        continuous_i = (drop > 0);
        src_valid_i = vld[0];
        while (cyc < e + 2) begin
            step();
            src_valid_i = vld[cyc - c0];
            continuous_i = (drop > 0) && (cyc < s + drop);
            if (cyc < e - 1) begin
                start_i = 1'($urandom);
                rate_i = 8'($urandom);
                burst_len_i = 16'($urandom);
                guard_len_i = 16'($urandom);
            end else begin
                start_i = 1'b0;
            end
        end
        rec = 0;
        chk({tag, "_nev"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            chk({tag, "_cyc"}, obs[i].c, expq[i].c);
            chk({tag, "_i"}, obs[i].i, expq[i].i);
            chk({tag, "_q"}, obs[i].q, expq[i].q);
            chk({tag, "_uf"}, obs[i].u, expq[i].u);
        end
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_donecyc"}, done_cyc, e);
        chk({tag, "_busyfall"}, busy_fall, e);
    endtask

    initial begin
        int   r, b, g, d;
        logic seen;
        rst_n_i = 1'b0;
        ena_i = 1'b0;
        start_i = 1'b0;
        continuous_i = 1'b0;
        rate_i = '0;
        burst_len_i = '0;
        guard_len_i = '0;
        src_valid_i = 1'b0;
        src_i_i = '0;
        src_q_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ctl", {strobe_o, busy_o, done_o, uflow_o, src_ready_o}, 0);
        chk("rst_tx", {tx_i_o, tx_q_o}, 0);
        chk("rst_cnt", uflow_cnt_o, 0);
        rst_n_i = 1'b1;
        ena_i = 1'b1;
        step();
        step();

        run_burst("oneshot", 3, 4, 2, 0, 100, -1);
        run_burst("uflow", 0, 5, 0, 0, 100, 2);
        chk("ucnt_one", uflow_cnt_o, exp_ucnt());
        run_burst("cont", 2, 2, 0, 30, 100, -1);
        run_burst("contg", 1, 3, 2, 25, 80, -1);
        for (int n = 0; n < 8; n++) begin
            r = $urandom_range(4);
            b = $urandom_range(6, 1);
            g = $urandom_range(3);
            d = ($urandom_range(1) == 1) ? $urandom_range(40, 1) : 0;
            run_burst("rnd", r, b, g, d, 70, -1);
        end
        chk("ucnt_rnd", uflow_cnt_o, exp_ucnt());

        // zero-length start is ignored
        burst_len_i = '0;
        start_i = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            step();
            seen |= busy_o;
        end
        chk("len0", seen, 0);

        // ena_i low beats a simultaneous start
        burst_len_i = 16'd3;
        ena_i = 1'b0;
        step();
        seen = busy_o;
        start_i = 1'b0;
        ena_i = 1'b1;
        step();
        seen |= busy_o;
        chk("st_ena", seen, 0);

        // abort mid-TX
        rate_i = 8'd1;
        burst_len_i = 16'd10;
        guard_len_i = '0;
        continuous_i = 1'b0;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (5) step();
        chk("ab_busy", busy_o, 1);
        ena_i = 1'b0;
        step();
        chk("ab_ctl", {busy_o, strobe_o, uflow_o, done_o}, 0);
        chk("ab_tx", {tx_i_o, tx_q_o}, 0);
        ena_i = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen |= src_ready_o | done_o | busy_o | strobe_o;
        end
        chk("ab_quiet", seen, 0);
        run_burst("restart", 1, 3, 1, 0, 100, -1);

`ifdef DAC_SEQ_UFLOW_CNT_EN
        // saturation: long continuous burst with no source data
        rate_i = 8'd0;
        burst_len_i = 16'hFFFF;
        guard_len_i = '0;
        continuous_i = 1'b1;
        src_valid_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (70000) @(posedge clk_i);
        #1;
        chk("sat", uflow_cnt_o, 32'hFFFF);
        ena_i = 1'b0;
        step();
        ena_i = 1'b1;
        continuous_i = 1'b0;
        step();
`endif

        // asynchronous reset in the guard interval
        rate_i = 8'd2;
        burst_len_i = 16'd2;
        guard_len_i = 16'd5;
        continuous_i = 1'b0;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (8) step();
        chk("ar_busy", busy_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("ar_ctl", {strobe_o, busy_o, done_o, uflow_o, src_ready_o}, 0);
        chk("ar_tx", {tx_i_o, tx_q_o}, 0);
        chk("ar_cnt", uflow_cnt_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        step();
        run_burst("post_rst", 0, 3, 1, 0, 60, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_tx_sequencer.md
# dac_tx_sequencer

Burst sequencer for the sounder transmit path. It sits between the transmit sample source and the DAC interface. It generates the I/Q sample strobe at a programmable rate and pulls samples from the source with a ready/valid handshake. It frames them into fixed-length bursts followed by zero-valued guard intervals, in one-shot or continuous mode, and substitutes zeros and flags an underflow whenever the source is not ready on a strobe.

## Interface
- LEN_W, 16, width of burst and guard length inputs and counters
- clk_i  in  1  system clock (64 MHz domain)
- rst_n_i  in  1  reset, asynchronous, active-low
- ena_i  in  1  master enable; low forces IDLE
- start_i  in  1  burst start request, level-sampled
- continuous_i  in  1  repeat burst after guard
- rate_i  in  8  strobe divisor; one strobe per rate_i+1 cycles
- burst_len_i  in  LEN_W  samples per burst
- guard_len_i  in  LEN_W  zero strobes after each burst
- src_valid_i  in  1  source sample available
- src_i_i, src_q_i  in  14 each  source I/Q sample
- src_ready_o  out  1  sample consumed this cycle when src_valid_i also high
- strobe_o  out  1  DAC interface strobe, one cycle wide
- tx_i_o, tx_q_o  out  14 each  I/Q to DAC interface
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle pulse on normal burst completion
- uflow_o  out  1  one-cycle pulse per underflowed strobe
- uflow_cnt_o  out  16  saturating underflow count (macro only)

## Operation
- States: IDLE, TX, GUARD.
- **IDLE**
  - Divider and sample counter are held at 0. tx_i_o and tx_q_o are 0. No strobes.
  - Transitions to TX when start_i & ena_i & (burst_len_i != 0).
  - On that transition, rate_i, burst_len_i and guard_len_i are latched. Changes to these inputs mid-burst are ignored.
  - start_i with burst_len_i == 0 is ignored.
- **Divider**
  - Counts 0..rate_q, then wraps to 0. Internal tick fires when the count is 0.
  - The divider is cleared on every entry to TX and to GUARD, so the first tick occurs in the first cycle of each state.
  - rate_i == 0 gives a tick every cycle.
- **TX**
  - src_ready_o = tick (combinational from registered state).
  - Tick with src_valid_i: tx_i_o/tx_q_o load src_i_i/src_q_i.
  - Tick without src_valid_i: tx_i_o/tx_q_o load 0 and uflow_o pulses. The sample counter still advances.
  - When the tick count reaches burst_len_q:
    - guard_len_q != 0: go to GUARD.
    - otherwise, continuous_i: stay in TX with counters restarted.
    - otherwise: go to IDLE and pulse done_o.
- **GUARD**
  - Each tick loads 0 to the outputs and strobes. src_ready_o stays 0.
  - After guard_len_q ticks: go to TX if continuous_i, else go to IDLE and pulse done_o.
- continuous_i is sampled only at the burst or guard end decision.
- start_i is ignored while busy_o is high.
- ena_i low in any state: IDLE on the next edge; outputs cleared; no done_o.
- If start_i and ena_i low occur in the same cycle, ena_i wins.

## Timing
- Reset value of every output is 0.
- strobe_o, tx_i_o, tx_q_o, uflow_o and done_o are registered.
- strobe_o is asserted in the cycle after the tick, the same cycle the new tx data appears. Handshake-to-DAC latency is 1 cycle.
- src_ready_o is combinational, high only in tick cycles while in TX.
- Strobe spacing is exactly rate_q+1 cycles within a state, including across the continuous TX wrap.
- Burst length, in cycles from the first to the last data strobe, is (burst_len_q-1)*(rate_q+1).
- done_o rises in the cycle busy_o falls.
- Assertion of rst_n_i mid-burst clears everything immediately. Operation resumes from IDLE after release.

## Configuration
- DAC_SEQ_UFLOW_CNT_EN
  - Defined: uflow_cnt_o increments on every uflow_o, saturates at 16'hFFFF, and clears only on reset.
  - Undefined: counter logic is absent and uflow_cnt_o is tied to 0. uflow_o is present in both builds.

## Test plan
- **One-shot burst:** rate_i=3, burst_len_i=4, guard_len_i=2, src always valid with samples 1..4 → 6 strobes spaced 4 cycles, data 1,2,3,4,0,0, then done_o pulse and busy_o low.
- **Underflow:** rate_i=0, burst_len_i=5, src_valid_i low on the 3rd tick → outputs s1,s2,0,s3,s4, one uflow_o pulse, uflow_cnt_o=1 (macro defined) / 0 (undefined).
- **Continuous mode:** burst_len_i=2, guard_len_i=0, continuous_i=1 → uninterrupted strobes every rate_i+1 cycles with no done_o; dropping continuous_i ends after the current burst with done_o.
- **Abort:** ena_i dropped mid-TX → IDLE next cycle, outputs 0, no done_o, no further src_ready_o; restart works.
- **Boundaries:** start_i with burst_len_i=0 → stays IDLE; changing rate_i mid-burst → spacing unchanged.
- **Saturation:** 70000 underflows → uflow_cnt_o holds 16'hFFFF.
- **Async reset:** rst_n_i asserted mid-GUARD → all outputs 0 without waiting for a clock edge.
